// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix loader and its word packer.
package matrix_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  localparam logic [1:0] STATUS_HOLD = 2'b00;
  localparam logic [1:0] STATUS_RUN  = 2'b01;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_CSUM  = 3'd3,
    S_START = 3'd4,
    S_RUN   = 3'd5
  } state_t;

endpackage

// File: rtl/matrix_word_packer.sv
// Byte-pair to word packer: latches the high byte, and on the low byte issues a
// one-cycle write of {hi,lo} at BASE_ADDR + word index (wrapping in ADDR_W bits).
module matrix_word_packer #(
  parameter int                ADDR_W    = matrix_pkg::ADDR_W,
  parameter int                DATA_W    = matrix_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [7:0]        in_data,
  output logic [7:0]        word_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  import matrix_pkg::*;

  logic [7:0] hi_byte;

  // Byte latch, word counter and registered write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_byte   <= 8'h00;
      word_idx  <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (clear) begin
        word_idx <= 8'd0;
      end else if (hi_load) begin
        hi_byte <= in_data;
      end else if (lo_load) begin
        mem_we    <= 1'b1;
        mem_wdata <= DATA_W'({hi_byte, in_data});
        mem_addr  <= BASE_ADDR + ADDR_W'(word_idx);
        word_idx  <= word_idx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: receives a length-prefixed byte stream, writes packed 16-bit
// words into data memory port 0, then starts the four cores and waits for them.
// Optional feature macro: CHECKSUM_EN (trailing checksum byte and sticky error).
module matrix_loader #(
  parameter int                ADDR_W    = matrix_pkg::ADDR_W,
  parameter int                DATA_W    = matrix_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int                NCORES    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              bus_own,
  output logic [1:0]        status,
  input  logic [NCORES-1:0] end_process,
  output logic              busy,
  output logic              done,
  output logic              error
);

  import matrix_pkg::*;

`ifdef CHECKSUM_EN
  localparam state_t AFTER_DATA = S_CSUM;
`else
  localparam state_t AFTER_DATA = S_START;
`endif

  state_t     state;
  logic [7:0] nwords;
  logic [7:0] word_idx;
  logic       accept;
  logic       last_word;
  logic       all_done;

  assign accept    = in_valid && in_ready;
  assign last_word = (word_idx == (nwords - 8'd1));
  assign all_done  = &end_process;

  matrix_word_packer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept && (state == S_LEN)),
    .hi_load  (accept && (state == S_HI)),
    .lo_load  (accept && (state == S_LO)),
    .in_data  (in_data),
    .word_idx (word_idx),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we)
  );

`ifdef CHECKSUM_EN
  logic [7:0] sum;

  // Running 8-bit sum of the stream and sticky checksum error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum   <= 8'h00;
      error <= 1'b0;
    end else if (accept) begin
      if (state == S_LEN) begin
        sum   <= in_data;
        error <= 1'b0;
      end else if ((state == S_CSUM) && ((sum + in_data) != 8'h00)) begin
        error <= 1'b1;
      end else begin
        sum <= sum + in_data;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

  // Load/run sequencer with registered handshake and core-control outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_LEN;
      nwords   <= 8'd0;
      in_ready <= 1'b1;
      bus_own  <= 1'b1;
      status   <= STATUS_HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LEN: begin
          if (accept) begin
            nwords <= in_data;
            busy   <= 1'b1;
            if (in_data == 8'd0) begin
              state    <= AFTER_DATA;
              in_ready <= (AFTER_DATA == S_CSUM);
            end else begin
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            state <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            if (last_word) begin
              state    <= AFTER_DATA;
              in_ready <= (AFTER_DATA == S_CSUM);
            end else begin
              state <= S_HI;
            end
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if ((sum + in_data) == 8'h00) begin
              state    <= S_START;
              in_ready <= 1'b0;
            end else begin
              state <= S_LEN;
              busy  <= 1'b0;
            end
          end
        end
`endif
        S_START: begin
          // The last word's write strobe is in this cycle; start cores after it.
          state   <= S_RUN;
          bus_own <= 1'b0;
          status  <= STATUS_RUN;
        end
        S_RUN: begin
          if (all_done) begin
            state    <= S_LEN;
            done     <= 1'b1;
            status   <= STATUS_HOLD;
            bus_own  <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= S_LEN;
          in_ready <= 1'b1;
          bus_own  <= 1'b1;
          status   <= STATUS_HOLD;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
